// File: rtl/seq_shift_unit_if.sv
// rtl/seq_shift_unit_if.sv - request/result bundle between the ALU control FSM and the shift unit
interface seq_shift_unit_if #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             start;
   logic [1:0]       mode;
   logic [SHW-1:0]   s;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] d_out;
   logic             carry;
   logic             busy;
   logic             done;

   modport master (
      output start, mode, s, d_in,
      input  d_out, carry, busy, done
   );

   modport slave (
      input  start, mode, s, d_in,
      output d_out, carry, busy, done
   );
endinterface

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle SRL/SRA/SLL/ROR shifter, up to STEP bits per cycle
module seq_shift_unit #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH),
   parameter int STEP  = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_shift_unit_if.slave bus
);
   localparam logic [31:0] MAX_S  = 32'(WIDTH - 1);
   localparam logic [31:0] STEP_U = 32'(STEP);

   localparam logic [1:0] M_SRL = 2'b00;
   localparam logic [1:0] M_SRA = 2'b01;
   localparam logic [1:0] M_SLL = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [SHW-1:0]   s_clamped;
   logic [31:0]      cnt_ext;
   logic [31:0]      k;
   logic [31:0]      rest;
   logic [SHW-1:0]   lsb_idx;
   logic [SHW-1:0]   msb_idx;
   logic [WIDTH-1:0] shifted;
   logic             step_carry;

   // Only reachable with a non-power-of-two WIDTH; otherwise s already fits.
   always_comb begin
      s_clamped = bus.s;
      if (32'(bus.s) > MAX_S) begin
         s_clamped = SHW'(MAX_S);
      end
   end

   // k is never 0 in SHIFT and never exceeds WIDTH-1, so both indices stay in range.
   always_comb begin
      cnt_ext    = 32'(cnt_q);
      k          = (cnt_ext > STEP_U) ? STEP_U : cnt_ext;
      rest       = cnt_ext - k;
      lsb_idx    = SHW'(k - 32'd1);
      msb_idx    = SHW'(32'(WIDTH) - k);
      shifted    = acc_q;
      step_carry = 1'b0;
      case (mode_q)
         M_SRL: begin
            shifted    = acc_q >> k;
            step_carry = acc_q[lsb_idx];
         end
         M_SRA: begin
            shifted    = $signed(acc_q) >>> k;
            step_carry = acc_q[lsb_idx];
         end
         M_SLL: begin
            shifted    = acc_q << k;
            step_carry = acc_q[msb_idx];
         end
         default: begin
            shifted    = (acc_q >> k) | (acc_q << (32'(WIDTH) - k));
            step_carry = acc_q[lsb_idx];
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      d_out_d = d_out_q;
      carry_d = carry_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               acc_d  = bus.d_in;
               cnt_d  = s_clamped;
               mode_d = bus.mode;
               if (s_clamped == '0) begin
                  state_d = ST_DONE;
                  d_out_d = bus.d_in;
                  carry_d = 1'b0;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            acc_d = shifted;
            cnt_d = SHW'(rest);
            if (rest == 32'd0) begin
               state_d = ST_DONE;
               d_out_d = shifted;
               carry_d = step_carry;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status flags are registered copies of the upcoming state.
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         d_out_q <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         d_out_q <= d_out_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.d_out = d_out_q;
   assign bus.carry = carry_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - randomized check of three shifter builds against a bit-serial model
module tb_seq_shift_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        st;
   logic [1:0]  md;
   logic [3:0]  sv;
   logic [15:0] dv;

   int total = 0;
   int bad   = 0;

   int WV[3] = '{16, 16, 12};
   int SP[3] = '{1, 4, 2};

   seq_shift_unit_if #(.WIDTH(16)) if0 ();
   seq_shift_unit_if #(.WIDTH(16)) if1 ();
   seq_shift_unit_if #(.WIDTH(12)) if2 ();

   seq_shift_unit #(.WIDTH(16), .STEP(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   seq_shift_unit #(.WIDTH(16), .STEP(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   seq_shift_unit #(.WIDTH(12), .STEP(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   assign if0.start = st;  assign if0.mode = md;  assign if0.s = sv;  assign if0.d_in = dv;
   assign if1.start = st;  assign if1.mode = md;  assign if1.s = sv;  assign if1.d_in = dv;
   assign if2.start = st;  assign if2.mode = md;  assign if2.s = sv;  assign if2.d_in = dv[11:0];

   logic [15:0] dout_a[3];
   logic        carry_a[3], busy_a[3], done_a[3];
   assign dout_a[0] = if0.d_out;         assign carry_a[0] = if0.carry;
   assign dout_a[1] = if1.d_out;         assign carry_a[1] = if1.carry;
   assign dout_a[2] = {4'h0, if2.d_out}; assign carry_a[2] = if2.carry;
   assign busy_a[0] = if0.busy;  assign busy_a[1] = if1.busy;  assign busy_a[2] = if2.busy;
   assign done_a[0] = if0.done;  assign done_a[1] = if1.done;  assign done_a[2] = if2.done;

   logic [15:0] res_d[3];
   logic        res_c[3];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One bit per iteration, straight from the fill rules; carry is the last bit to leave.
   function automatic logic [16:0] ref_op(input int w, input logic [1:0] m, input int sh,
                                          input logic [15:0] d);
      logic [15:0] a, msk;
      logic c;
      msk = 16'hffff >> (16 - w);
      a   = d & msk;
      c   = 1'b0;
      for (int i = 0; i < sh; i++) begin
         case (m)
            2'd0: begin c = a[0];   a = a >> 1; end
            2'd1: begin c = a[0];   a = (a >> 1) | ({15'h0, a[w-1]} << (w - 1)); end
            2'd2: begin c = a[w-1]; a = (a << 1) & msk; end
            default: begin c = a[0]; a = (a >> 1) | ({15'h0, c} << (w - 1)); end
         endcase
      end
      return {c, a};
   endfunction

   task automatic run_op(input logic [1:0] m, input logic [3:0] sh, input logic [15:0] d,
                         input bit intrude);
      int dcnt[3], dcyc[3], bcnt[3], lat[3], eff;
      logic [16:0] exp_r[3];
      @(negedge clk);
      st = 1'b1; md = m; sv = sh; dv = d;
      for (int i = 0; i < 3; i++) begin
         eff      = (int'(sh) > WV[i] - 1) ? WV[i] - 1 : int'(sh);
         exp_r[i] = ref_op(WV[i], m, eff, d);
         lat[i]   = 1 + (eff + SP[i] - 1) / SP[i];
         dcnt[i] = 0; dcyc[i] = 0; bcnt[i] = 0;
      end
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         // Inputs wander after the start edge; an extra start lands while the op is in flight.
         st = (c == 1) ? intrude : 1'b0;
         md = 2'($urandom); sv = 4'($urandom); dv = 16'($urandom);
         for (int i = 0; i < 3; i++) begin
            if (busy_a[i]) bcnt[i]++;
            if (done_a[i]) begin
               dcnt[i]++;
               dcyc[i] = c;
               res_d[i] = dout_a[i];
               res_c[i] = carry_a[i];
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("dut%0d m%0d s%0d done_count", i, m, sh), dcnt[i], 1);
         check_eq($sformatf("dut%0d m%0d s%0d done_cycle", i, m, sh), dcyc[i], lat[i]);
         check_eq($sformatf("dut%0d m%0d s%0d busy_cycles", i, m, sh), bcnt[i], lat[i] - 1);
         check_eq($sformatf("dut%0d m%0d s%0d d_out", i, m, sh), res_d[i], exp_r[i][15:0]);
         check_eq($sformatf("dut%0d m%0d s%0d carry", i, m, sh), res_c[i], exp_r[i][16]);
         check_eq($sformatf("dut%0d m%0d s%0d d_out_hold", i, m, sh), dout_a[i], exp_r[i][15:0]);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("%s dut%0d d_out", tag, i), dout_a[i], 0);
         check_eq($sformatf("%s dut%0d carry", tag, i), carry_a[i], 0);
         check_eq($sformatf("%s dut%0d busy", tag, i), busy_a[i], 0);
         check_eq($sformatf("%s dut%0d done", tag, i), done_a[i], 0);
      end
   endtask

   initial begin
      int seen;
      st = 1'b0; md = 2'd0; sv = 4'd0; dv = 16'h0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("idle");

      run_op(2'd0, 4'd4, 16'hcdef, 1'b0);
      check_eq("plan srl4 d_out", res_d[0], 16'h0cde);
      check_eq("plan srl4 carry", res_c[0], 1'b1);
      run_op(2'd1, 4'd4, 16'hcdef, 1'b0);
      check_eq("plan sra4 d_out", res_d[0], 16'hfcde);
      check_eq("plan sra4 carry", res_c[0], 1'b1);
      run_op(2'd2, 4'd4, 16'hcdef, 1'b0);
      check_eq("plan sll4 d_out", res_d[0], 16'hdef0);
      check_eq("plan sll4 carry", res_c[0], 1'b0);
      run_op(2'd3, 4'd4, 16'hcdef, 1'b0);
      check_eq("plan ror4 d_out", res_d[0], 16'hfcde);
      check_eq("plan ror4 carry", res_c[0], 1'b1);
      run_op(2'd1, 4'd0, 16'hcdef, 1'b0);
      check_eq("plan sra0 d_out", res_d[0], 16'hcdef);
      check_eq("plan sra0 carry", res_c[0], 1'b0);
      run_op(2'd1, 4'd15, 16'hcdef, 1'b0);
      check_eq("plan sra15 d_out", res_d[0], 16'hffff);
      check_eq("plan sra15 carry", res_c[0], 1'b1);
      run_op(2'd0, 4'd15, 16'hcdef, 1'b0);
      check_eq("plan step4 srl15 d_out", res_d[1], 16'h0001);
      check_eq("plan step4 srl15 carry", res_c[1], 1'b1);
      run_op(2'd3, 4'd6, 16'hcdef, 1'b0);
      check_eq("plan step4 ror6 d_out", res_d[1], 16'hbf37);
      run_op(2'd0, 4'd8, 16'hcdef, 1'b1);
      check_eq("plan ignored start d_out", res_d[0], 16'h00cd);
      check_eq("plan ignored start carry", res_c[0], 1'b1);

      // Abort mid-operation with reset, then confirm no stray done and a clean restart.
      @(negedge clk);
      st = 1'b1; md = 2'd2; sv = 4'd10; dv = 16'hcdef;
      @(negedge clk);
      st = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1 check_zero("async_reset");
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 2) rst_n = 1'b1;
         for (int i = 0; i < 3; i++) if (done_a[i] || busy_a[i]) seen++;
      end
      check_eq("no done/busy after abort", seen, 0);
      check_zero("after_abort");
      run_op(2'd2, 4'd10, 16'hcdef, 1'b0);
      check_eq("post reset sll10 d_out", res_d[0], 16'hbc00);
      check_eq("post reset sll10 carry", res_c[0], 1'b1);

      for (int n = 0; n < 40; n++) begin
         run_op(2'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Parametrised, multi-cycle successor to the combinational 16-bit right shifter in the ALU datapath. It adds four shift modes, a configurable shift step per cycle, a start/busy/done handshake and a carry-out flag. The ALU control FSM uses it when area matters more than single-cycle latency.

Parameters:
WIDTH, 16, data width in bits; must be at least 2.
SHW, $clog2(WIDTH), width of the shift-amount port.
STEP, 1, maximum bits shifted per cycle; power of two, 1 <= STEP <= WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
mode  input  2  shift mode: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
s  input  SHW  shift amount, 0..WIDTH-1.
d_in  input  WIDTH  operand.
d_out  output  WIDTH  registered result.
carry  output  1  last bit shifted or rotated out.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when d_out and carry become valid.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, d_out=0, carry=0, busy=0, done=0, internal acc=0, cnt=0, mode register=0.
- State machine: IDLE -> SHIFT -> DONE -> IDLE. If s==0, IDLE goes directly to DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: acc<=d_in, cnt<=s, mode latched.
  - Next state is SHIFT if s!=0, otherwise DONE with d_out<=d_in and carry<=0.
- SHIFT:
  - busy=1.
  - Each edge: k=min(cnt,STEP); acc shifted by k bits per the latched mode; cnt<=cnt-k.
  - Mode fill rules: SRL fills the MSBs with 0. SRA fills with acc[WIDTH-1]. SLL fills the LSBs with 0. ROR moves the LSBs into the MSBs.
  - carry tracks the last bit leaving the LSB end (SRL/SRA/ROR) or the MSB end (SLL).
  - On the edge where cnt-k==0: d_out<=shifted acc, carry updated, next state DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; next state IDLE.
  - d_out and carry hold until the next DONE or reset.
- Latency: done is high during cycle 1+ceil(s/STEP) after the edge that sampled start. Example: WIDTH=16, STEP=1, s=4 gives 5 cycles.
- The earliest next accepted start is the edge after DONE, i.e. in IDLE.
- start while in SHIFT or DONE is ignored; no queueing, and inputs are not re-sampled.
- mode, s and d_in may change freely after the start edge without affecting the operation in flight.
- Reset mid-operation aborts immediately: all outputs return to reset values and no done pulse is issued.
- s is unsigned. With a non-power-of-two WIDTH, values >= WIDTH are clamped to WIDTH-1.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. WIDTH=16, STEP=1; start with mode=00, s=4, d_in=16'hcdef -> busy high 4 cycles, done high in cycle 5, d_out=16'h0cde, carry=1.
2. Same operand, s=4, modes 01/10/11 in turn -> SRA d_out=16'hfcde carry=1; SLL d_out=16'hdef0 carry=0; ROR d_out=16'hfcde carry=1.
3. mode=01, s=0, d_in=16'hcdef -> done in cycle 1, busy never high, d_out=16'hcdef, carry=0. Then mode=01, s=15 -> d_out=16'hffff, carry=1, done in cycle 16.
4. STEP=4 build, mode=00, s=15, d_in=16'hcdef -> done in cycle 5 (1+4), d_out=16'h0001, carry=1. STEP=4, mode=11, s=6 -> d_out=16'hbf37, done in cycle 3.
5. Start SRL s=8 on 16'hcdef, then pulse start with d_in=16'h1234, s=1 during SHIFT -> second request ignored; single done with d_out=16'h00cd, carry=1.
6. Start SLL s=10, deassert rst_n mid-SHIFT for 3 cycles -> d_out=0, carry=0, busy=0, done never pulses. A fresh start after release completes normally.
